// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared register-file word/select types and the hardwired-zero register index
package cpu_types_pkg;
   localparam int DATA_W = 32;
   localparam int SELW = 5;
   localparam int RF_ZERO = 0;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [SELW-1:0] regbits_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with highest-index-wins write bypass
module rf_read_port
   import cpu_types_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS = 32,
   parameter int NWR = 2,
   parameter int BYPASS = 1,
   parameter int SELW = $clog2(NREGS)
) (
   input logic [SELW-1:0] sel,
   input logic [DATA_W-1:0] regs [NREGS],
   input logic [NREGS-1:0] busy,
   input logic wen [NWR],
   input logic [SELW-1:0] wsel [NWR],
   input logic [DATA_W-1:0] wdat [NWR],
   output logic [DATA_W-1:0] dat,
   output logic bsy
);
   always_comb begin
      dat = regs[sel];
      bsy = busy[sel];
      for (int k = 0; k < NWR; k++)
         if (BYPASS != 0 && int'(sel) != RF_ZERO && wen[k] && wsel[k] == sel) begin
            dat = wdat[k];
            bsy = 1'b0;
         end
   end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with write bypass and per-register pending bits
module register_file_mp
   import cpu_types_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS = 32,
   parameter int NRD = 2,
   parameter int NWR = 2,
   parameter int BYPASS = 1,
   localparam int SELW = $clog2(NREGS),
   localparam int CW = $clog2(NREGS + 1)
) (
   input logic CLK,
   input logic nRST,
   input logic [SELW-1:0] rsel [NRD],
   output logic [DATA_W-1:0] rdat [NRD],
   output logic rbusy [NRD],
   input logic wen [NWR],
   input logic [SELW-1:0] wsel [NWR],
   input logic [DATA_W-1:0] wdat [NWR],
   input logic alloc_en,
   input logic [SELW-1:0] alloc_sel,
   input logic flush,
   output logic [CW-1:0] busy_cnt
);
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] wr_dat [NREGS];
   logic [NREGS-1:0] wr_hit, busy_q, busy_d;
   logic [CW-1:0] cnt_d;
   logic wen_v [NWR];
   always_comb begin
      for (int k = 0; k < NWR; k++)
         wen_v[k] = wen[k] & nRST;
   end
   // later ports overwrite earlier ones, so the highest-index writer wins
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         wr_hit[r] = 1'b0;
         wr_dat[r] = '0;
         for (int k = 0; k < NWR; k++)
            if (wen[k] && int'(wsel[k]) == r && r != RF_ZERO) begin
               wr_hit[r] = 1'b1;
               wr_dat[r] = wdat[k];
            end
      end
   end
   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (alloc_en && int'(alloc_sel) != RF_ZERO)
         busy_d[alloc_sel] = 1'b1;
      if (flush)
         busy_d = '0;
      cnt_d = '0;
      for (int r = 0; r < NREGS; r++)
         cnt_d = cnt_d + CW'(busy_d[r]);
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int r = 0; r < NREGS; r++)
            regs_q[r] <= '0;
         busy_q <= '0;
         busy_cnt <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++)
            if (wr_hit[r])
               regs_q[r] <= wr_dat[r];
         busy_q <= busy_d;
         busy_cnt <= cnt_d;
      end
   end
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      rf_read_port #(
         .DATA_W(DATA_W),
         .NREGS(NREGS),
         .NWR(NWR),
         .BYPASS(BYPASS),
         .SELW(SELW)
      ) u_rd (
         .sel(rsel[i]),
         .regs(regs_q),
         .busy(busy_q),
         .wen(wen_v),
         .wsel(wsel),
         .wdat(wdat),
         .dat(rdat[i]),
         .bsy(rbusy[i])
      );
   end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: bypass and non-bypass instances driven in lockstep against a rule-level model
module tb_register_file_mp;
   logic CLK = 1'b0;
   logic nRST;
   logic [4:0] rsel [2];
   logic [31:0] rdat_b [2];
   logic [31:0] rdat_n [2];
   logic rbusy_b [2];
   logic rbusy_n [2];
   logic wen [2];
   logic [4:0] wsel [2];
   logic [31:0] wdat [2];
   logic alloc_en, flush;
   logic [4:0] alloc_sel;
   logic [5:0] cnt_b, cnt_n;
   int total = 0;
   int bad = 0;
   logic [31:0] m_mem [32];
   logic [31:0] m_busy;

   typedef struct {
      logic [4:0] rs0, rs1;
      logic we0; logic [4:0] ws0; logic [31:0] wd0;
      logic we1; logic [4:0] ws1; logic [31:0] wd1;
      logic al; logic [4:0] as; logic fl;
      logic [31:0] ed0, ed1; logic eb0, eb1; logic [5:0] ec;
   } vec_t;
   vec_t vec [11];

   always #5 CLK = ~CLK;

   register_file_mp #(.BYPASS(1)) dut_b (
      .CLK(CLK), .nRST(nRST), .rsel(rsel), .rdat(rdat_b), .rbusy(rbusy_b),
      .wen(wen), .wsel(wsel), .wdat(wdat), .alloc_en(alloc_en),
      .alloc_sel(alloc_sel), .flush(flush), .busy_cnt(cnt_b)
   );
   register_file_mp #(.BYPASS(0)) dut_n (
      .CLK(CLK), .nRST(nRST), .rsel(rsel), .rdat(rdat_n), .rbusy(rbusy_n),
      .wen(wen), .wsel(wsel), .wdat(wdat), .alloc_en(alloc_en),
      .alloc_sel(alloc_sel), .flush(flush), .busy_cnt(cnt_n)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      wen[0] = 1'b0; wen[1] = 1'b0;
      wsel[0] = '0; wsel[1] = '0;
      wdat[0] = '0; wdat[1] = '0;
      alloc_en = 1'b0; alloc_sel = '0; flush = 1'b0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++)
         m_mem[r] = '0;
      m_busy = '0;
   endtask

   task automatic check_model();
      logic [31:0] ed;
      logic eb;
      for (int i = 0; i < 2; i++) begin
         ed = m_mem[rsel[i]];
         eb = m_busy[rsel[i]];
         chk("nb_rdat", rdat_n[i], ed);
         chk("nb_rbusy", 32'(rbusy_n[i]), 32'(eb));
         if (rsel[i] != 5'd0)
            for (int k = 0; k < 2; k++)
               if (wen[k] && wsel[k] == rsel[i]) begin
                  ed = wdat[k];
                  eb = 1'b0;
               end
         chk("bp_rdat", rdat_b[i], ed);
         chk("bp_rbusy", 32'(rbusy_b[i]), 32'(eb));
      end
      chk("bp_cnt", 32'(cnt_b), 32'($countones(m_busy)));
      chk("nb_cnt", 32'(cnt_n), 32'($countones(m_busy)));
   endtask

   task automatic model_update();
      for (int k = 0; k < 2; k++)
         if (wen[k] && wsel[k] != 5'd0) begin
            m_mem[wsel[k]] = wdat[k];
            m_busy[wsel[k]] = 1'b0;
         end
      if (alloc_en && alloc_sel != 5'd0)
         m_busy[alloc_sel] = 1'b1;
      if (flush)
         m_busy = '0;
   endtask

   task automatic step();
      #1;
      check_model();
      @(posedge CLK);
      model_update();
      @(negedge CLK);
   endtask

   initial begin
      vec[0]  = '{5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'h0, 1'b0, 1'b0, 6'd0};
      vec[1]  = '{5'd5, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'h0, 1'b0, 1'b0, 6'd0};
      vec[2]  = '{5'd5, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
      vec[3]  = '{5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
      vec[4]  = '{5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 6'd1};
      vec[5]  = '{5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 32'h33, 32'h33, 1'b0, 1'b0, 6'd1};
      vec[6]  = '{5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h33, 32'h0, 1'b0, 1'b0, 6'd0};
      vec[7]  = '{5'd3, 5'd0, 1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 6'd0};
      vec[8]  = '{5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 6'd1};
      vec[9]  = '{5'd0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h44, 1'b0, 1'b1, 6'd1};
      vec[10] = '{5'd0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h44, 1'b0, 1'b1, 6'd1};

      // reset: writes attempted under reset must not stick
      nRST = 1'b0;
      idle();
      rsel[0] = '0; rsel[1] = '0;
      wen[0] = 1'b1; wsel[0] = 5'd9; wdat[0] = 32'h1234;
      wen[1] = 1'b1; wsel[1] = 5'd5; wdat[1] = 32'h5678;
      alloc_en = 1'b1; alloc_sel = 5'd2;
      @(posedge CLK); @(posedge CLK); @(negedge CLK);
      idle();
      for (int r = 0; r < 32; r++) begin
         rsel[0] = 5'(r); rsel[1] = 5'(31 - r);
         #1;
         chk("rst_rdat_b", rdat_b[0], 32'h0);
         chk("rst_rdat_n", rdat_n[1], 32'h0);
         chk("rst_rbusy_b", 32'(rbusy_b[1]), 32'h0);
         chk("rst_rbusy_n", 32'(rbusy_n[0]), 32'h0);
      end
      chk("rst_cnt", 32'(cnt_b), 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
      model_reset();
      rsel[0] = 5'd9; rsel[1] = 5'd5;
      step();
      step();

      for (int n = 0; n < 11; n++) begin
         rsel[0] = vec[n].rs0; rsel[1] = vec[n].rs1;
         wen[0] = vec[n].we0; wsel[0] = vec[n].ws0; wdat[0] = vec[n].wd0;
         wen[1] = vec[n].we1; wsel[1] = vec[n].ws1; wdat[1] = vec[n].wd1;
         alloc_en = vec[n].al; alloc_sel = vec[n].as; flush = vec[n].fl;
         #1;
         chk($sformatf("tbl%0d_rdat0", n), rdat_b[0], vec[n].ed0);
         chk($sformatf("tbl%0d_rdat1", n), rdat_b[1], vec[n].ed1);
         chk($sformatf("tbl%0d_rbusy0", n), 32'(rbusy_b[0]), 32'(vec[n].eb0));
         chk($sformatf("tbl%0d_rbusy1", n), 32'(rbusy_b[1]), 32'(vec[n].eb1));
         chk($sformatf("tbl%0d_cnt", n), 32'(cnt_b), 32'(vec[n].ec));
         step();
      end

      // no-bypass instance sees pre-edge state until the write lands
      idle();
      rsel[0] = 5'd7; rsel[1] = 5'd3;
      wen[0] = 1'b1; wsel[0] = 5'd7; wdat[0] = 32'h77;
      wen[1] = 1'b1; wsel[1] = 5'd3; wdat[1] = 32'h55;
      #1;
      chk("byp_new", rdat_b[0], 32'h77);
      chk("nobyp_old", rdat_n[0], 32'hA5A5A5A5);
      chk("byp_busy_clr", 32'(rbusy_b[1]), 32'h0);
      chk("nobyp_busy_held", 32'(rbusy_n[1]), 32'h1);
      step();
      idle();
      #1;
      chk("nobyp_new", rdat_n[0], 32'h77);
      chk("nobyp_r3", rdat_n[1], 32'h55);
      chk("nobyp_busy_clr", 32'(rbusy_n[1]), 32'h0);
      step();

      for (int r = 1; r < 32; r++) begin
         alloc_en = 1'b1; alloc_sel = 5'(r);
         step();
      end
      idle();
      #1;
      chk("all_busy_cnt_b", 32'(cnt_b), 32'd31);
      chk("all_busy_cnt_n", 32'(cnt_n), 32'd31);
      flush = 1'b1; alloc_en = 1'b1; alloc_sel = 5'd4;
      step();
      idle();
      #1;
      chk("flush_cnt", 32'(cnt_b), 32'h0);
      for (int r = 0; r < 32; r++) begin
         rsel[0] = 5'(r); rsel[1] = 5'(r);
         #1;
         chk("flush_rbusy_b", 32'(rbusy_b[0]), 32'h0);
         chk("flush_rbusy_n", 32'(rbusy_n[1]), 32'h0);
      end
      @(negedge CLK);
      alloc_en = 1'b1; alloc_sel = 5'd0;
      step();
      idle();
      #1;
      chk("alloc_r0_cnt", 32'(cnt_b), 32'h0);

      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 2; k++) begin
            wen[k] = 1'($urandom);
            wsel[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wdat[k] = $urandom;
         end
         for (int i = 0; i < 2; i++)
            rsel[i] = ($urandom_range(0, 2) == 0) ? wsel[i] : 5'($urandom_range(0, 31));
         alloc_en = ($urandom_range(0, 2) != 0);
         alloc_sel = 5'($urandom_range(0, 31));
         flush = ($urandom_range(0, 31) == 0);
         step();
      end

      // asynchronous reset in the middle of a cycle with state outstanding
      idle();
      step();
      flush = 1'b1;
      step();
      for (int r = 1; r <= 10; r++) begin
         idle();
         alloc_en = 1'b1; alloc_sel = 5'(r);
         wen[0] = 1'b1; wsel[0] = 5'(r + 10); wdat[0] = 32'hC0DE0000 + 32'(r);
         step();
      end
      idle();
      #1;
      chk("pre_rst_cnt", 32'(cnt_b), 32'd10);
      #1;
      nRST = 1'b0;
      #1;
      chk("async_rst_cnt_b", 32'(cnt_b), 32'h0);
      chk("async_rst_cnt_n", 32'(cnt_n), 32'h0);
      for (int r = 0; r < 32; r++) begin
         rsel[0] = 5'(r); rsel[1] = 5'(r);
         #1;
         chk("async_rst_rdat", rdat_b[0], 32'h0);
         chk("async_rst_rdat_n", rdat_n[1], 32'h0);
         chk("async_rst_rbusy", 32'(rbusy_b[1]), 32'h0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
